// File: rtl/input_conditioner_bank.sv
// Multi-channel pin conditioner: per-channel polarity fix, synchronizer chain,
// debounce counter and registered edge pulses, plus a bus-wide anyedge strobe.
module input_conditioner_bank #(
  parameter int               WIDTH        = 4,
  parameter int               SYNCSTAGES   = 2,
  parameter int               COUNTERWIDTH = 3,
  parameter int               WAITTIME     = 3,
  parameter logic [WIDTH-1:0] INVERTMASK   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] noisysignal,
  output logic [WIDTH-1:0] conditioned,
  output logic [WIDTH-1:0] positiveedge,
  output logic [WIDTH-1:0] negativeedge,
  output logic             anyedge
);

  localparam logic [COUNTERWIDTH-1:0] WAIT_C = COUNTERWIDTH'(WAITTIME);

  logic [WIDTH-1:0]        sync_q [SYNCSTAGES];
  logic [COUNTERWIDTH-1:0] cnt_q  [WIDTH];
  logic [COUNTERWIDTH-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0]        cond_q, cond_d;
  logic [WIDTH-1:0]        pos_q, pos_d;
  logic [WIDTH-1:0]        neg_q, neg_d;
  logic                    any_q, any_d;
  logic [WIDTH-1:0]        sync_last;

  assign sync_last = sync_q[SYNCSTAGES-1];

  // A change is accepted only on the (WAITTIME+1)-th consecutive disagreeing
  // cycle; any agreement clears the count, so it can never pass WAIT_C.
  always_comb begin
    cond_d = cond_q;
    pos_d  = '0;
    neg_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != cond_q[i]) begin
        if (cnt_q[i] == WAIT_C) begin
          cond_d[i] = sync_last[i];
          pos_d[i]  = sync_last[i];
          neg_d[i]  = ~sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + COUNTERWIDTH'(1);
        end
      end
    end
    any_d = |{pos_q, neg_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNCSTAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      cond_q <= '0;
      pos_q  <= '0;
      neg_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      sync_q[0] <= noisysignal ^ INVERTMASK;
      for (int s = 1; s < SYNCSTAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      cond_q <= cond_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
      any_q  <= any_d;
    end
  end

  assign conditioned  = cond_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;
  assign anyedge      = any_q;

endmodule

// File: tb/tb_input_conditioner_bank.sv
// Directed bench for input_conditioner_bank: default instance plus an instance
// with channel 2 inverted, both checked against hand-computed expectations.
module tb_input_conditioner_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] noisy;
  logic [3:0] noisy_inv;
  logic [3:0] cond, pos, neg;
  logic       any;
  logic [3:0] cond_i, pos_i, neg_i;
  logic       any_i;
  int         tests = 0;
  int         fails = 0;
  logic [8:0] bounce;

  always #5 clk = ~clk;

  input_conditioner_bank u_dut (
    .clk(clk), .reset(reset), .noisysignal(noisy),
    .conditioned(cond), .positiveedge(pos), .negativeedge(neg), .anyedge(any)
  );

  input_conditioner_bank #(.INVERTMASK(4'b0100)) u_inv (
    .clk(clk), .reset(reset), .noisysignal(noisy_inv),
    .conditioned(cond_i), .positiveedge(pos_i), .negativeedge(neg_i), .anyedge(any_i)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input logic [3:0] ec, input logic [3:0] ep,
                         input logic [3:0] en, input logic ea);
    chk({tag, "_cond"}, cond, ec);
    chk({tag, "_pos"},  pos,  ep);
    chk({tag, "_neg"},  neg,  en);
    chk({tag, "_any"},  {3'b000, any}, {3'b000, ea});
  endtask

  task automatic chk_inv(input string tag, input logic [3:0] ec, input logic [3:0] ep,
                         input logic ea);
    chk({tag, "_icond"}, cond_i, ec);
    chk({tag, "_ipos"},  pos_i,  ep);
    chk({tag, "_ineg"},  neg_i,  4'b0000);
    chk({tag, "_iany"},  {3'b000, any_i}, {3'b000, ea});
  endtask

  initial begin
    reset     = 1'b1;
    noisy     = 4'b0000;
    noisy_inv = 4'b0000;
    cyc();
    cyc();
    chk_dut("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk_inv("reset", 4'b0000, 4'b0000, 1'b0);

    // Release reset with ch0 rising; inverted ch2 debounces up simultaneously.
    reset = 1'b0;
    noisy = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk_dut($sformatf("rise_k%0d", k), (k >= 6) ? 4'b0001 : 4'b0000,
              (k == 6) ? 4'b0001 : 4'b0000, 4'b0000, k == 7);
      chk_inv($sformatf("inv_k%0d", k), (k >= 6) ? 4'b0100 : 4'b0000,
              (k == 6) ? 4'b0100 : 4'b0000, k == 7);
    end

    // Three-cycle glitch on ch1 is rejected.
    noisy = 4'b0011;
    cyc();
    cyc();
    cyc();
    noisy = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk_dut($sformatf("glitch_k%0d", k), 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end

    // Four-cycle pulse on ch1 is accepted, then released.
    noisy = 4'b0011;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk_dut($sformatf("pulse_k%0d", k),
              (k >= 6 && k < 10) ? 4'b0011 : 4'b0001,
              (k == 6) ? 4'b0010 : 4'b0000,
              (k == 10) ? 4'b0010 : 4'b0000,
              (k == 7 || k == 11));
      if (k == 4) noisy = 4'b0001;
    end

    // Bouncing ch1: pins 1,0,1,1,0,1,1,1,1 then steady high.
    bounce = 9'b111101101;
    for (int k = 0; k < 14; k++) begin
      noisy[1] = (k < 9) ? bounce[k] : 1'b1;
      cyc();
      chk_dut($sformatf("bounce_k%0d", k + 1),
              (k + 1 >= 11) ? 4'b0011 : 4'b0001,
              (k + 1 == 11) ? 4'b0010 : 4'b0000,
              4'b0000, (k + 1 == 12));
    end

    // Move to ch0=0, ch3=1, then swap both in the same cycle.
    noisy = 4'b1010;
    for (int k = 0; k < 8; k++) cyc();
    chk_dut("prep", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    noisy = 4'b0011;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk_dut($sformatf("simul_k%0d", k), (k >= 6) ? 4'b0011 : 4'b1010,
              (k == 6) ? 4'b0001 : 4'b0000,
              (k == 6) ? 4'b1000 : 4'b0000, k == 7);
    end

    // Reset while ch2 count is 2, then full latency after release.
    noisy = 4'b0111;
    for (int k = 0; k < 4; k++) cyc();
    chk_dut("premid", 4'b0011, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    cyc();
    chk_dut("midreset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk_inv("midreset", 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk_dut($sformatf("post_k%0d", k), (k >= 6) ? 4'b0111 : 4'b0000,
              (k == 6) ? 4'b0111 : 4'b0000, 4'b0000, k == 7);
      chk_inv($sformatf("ipost_k%0d", k), (k >= 6) ? 4'b0100 : 4'b0000,
              (k == 6) ? 4'b0100 : 4'b0000, k == 7);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
